// File: rtl/bcd_sched_pkg.sv
// Shared definitions for the BCD conversion scheduler: state encoding,
// requester count and default WAIT timeout.
package bcd_sched_pkg;

   localparam int unsigned NumReq     = 2;
   localparam int unsigned DefTimeout = 64;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StGuard,
      StWait,
      StDone
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins;
// a lone request always wins.
module rr_arb2
   import bcd_sched_pkg::*;
(
   input  logic [NumReq-1:0] req,
   input  logic              last,
   output logic [NumReq-1:0] grant
);

   always_comb begin
      grant = '0;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/bcd_conv_sched.sv
// Schedules two requesters onto one external binary-to-BCD converter, with a
// guard cycle against stale done levels and a bounded wait for completion.
module bcd_conv_sched
   import bcd_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NumReq-1:0] req,
   input  logic [11:0]       bin_a,
   input  logic [11:0]       bin_b,
   output logic [NumReq-1:0] ack,
   output logic [15:0]       bcd_res,
   output logic              err,
   output logic              conv_en,
   output logic [11:0]       conv_bin,
   input  logic [15:0]       conv_bcd,
   input  logic              conv_rdy
);

   localparam int unsigned       TimerW    = $clog2(TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

   state_e            state_q;
   logic [NumReq-1:0] grant;
   logic [NumReq-1:0] gnt_q;
   logic              last_q;
   logic [TimerW-1:0] timer_q;

   rr_arb2 u_arb (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         last_q   <= 1'b1;
         timer_q  <= '0;
         ack      <= '0;
         conv_en  <= 1'b0;
         err      <= 1'b0;
         bcd_res  <= '0;
         conv_bin <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (|req) begin
                  gnt_q    <= grant;
                  conv_bin <= grant[0] ? bin_a : bin_b;
                  conv_en  <= 1'b1;
                  state_q  <= StStart;
               end
            end
            StStart: begin
               conv_en <= 1'b0;
               state_q <= StGuard;
            end
            // conv_rdy may still be high from the previous job; skip it here.
            StGuard: begin
               timer_q <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (conv_rdy) begin
                  bcd_res <= conv_bcd;
                  err     <= 1'b0;
                  ack     <= gnt_q;
                  state_q <= StDone;
               end else if (timer_q == TimerLast) begin
                  bcd_res <= '0;
                  err     <= 1'b1;
                  ack     <= gnt_q;
                  state_q <= StDone;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StDone: begin
               ack     <= '0;
               last_q  <= gnt_q[1];
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
